// File: rtl/reg_file_arb.sv
// reg_file_arb: two-requester round-robin arbiter in front of a single-port
// register file. One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//
// Optional feature: define REG_FILE_ARB_TIMEOUT_EN to enable a WAIT-state timeout.
// After TIMEOUT_CYC cycles in WAIT without rf_ack the requester gets a response
// with m_rd_data = 0 and m_err = all ones.
//
// state | meaning
// IDLE  | no transaction, arbitrate on m_req
// ISSUE | rf_req high for one cycle with the captured fields
// WAIT  | waiting for rf_ack (or for the timeout, when enabled)
// RESP  | m_ack pulse to the winner, response data valid
module reg_file_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ERR_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          m_req,
  input  logic [1:0]          m_wr,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [2*DATA_W-1:0] m_wr_data,
  output logic [1:0]          m_gnt,
  output logic [1:0]          m_ack,
  output logic [DATA_W-1:0]   m_rd_data,
  output logic [ERR_W-1:0]    m_err,
  output logic                rf_req,
  output logic                rf_wr,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  input  logic [DATA_W-1:0]   rf_rd_data,
  input  logic                rf_ack,
  input  logic [ERR_W-1:0]    rf_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic   rr_ptr;
  logic   winner;
  logic   win_nx;
  logic   timeout;

`ifdef REG_FILE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] to_cnt;

  // Counts cycles spent in WAIT; zeroed during ISSUE so it starts at 0 on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == WAIT) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Winner selection: a lone requester wins, otherwise rr_ptr decides.
  always_comb begin
    win_nx = rr_ptr;
    if (m_req == 2'b01) win_nx = 1'b0;
    else if (m_req == 2'b10) win_nx = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; rf_ack only matters in WAIT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|m_req) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (rf_ack || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture request at grant, capture response leaving WAIT, advance rr_ptr after RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      winner     <= 1'b0;
      m_gnt      <= 2'b00;
      rf_wr      <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      m_rd_data  <= '0;
      m_err      <= '0;
    end else begin
      m_gnt <= 2'b00;
      if (state == IDLE && |m_req) begin
        winner     <= win_nx;
        m_gnt      <= win_nx ? 2'b10 : 2'b01;
        rf_wr      <= m_wr[win_nx];
        rf_addr    <= win_nx ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
        rf_wr_data <= win_nx ? m_wr_data[2*DATA_W-1:DATA_W] : m_wr_data[DATA_W-1:0];
      end
      if (state == WAIT) begin
        if (rf_ack) begin
          m_rd_data <= rf_wr ? '0 : rf_rd_data;
          m_err     <= rf_err;
        end else if (timeout) begin
          m_rd_data <= '0;
          m_err     <= '1;
        end
      end
      if (state == RESP) rr_ptr <= ~winner;
    end
  end

  assign rf_req = (state == ISSUE);
  assign busy   = (state != IDLE);
  assign m_ack  = (state == RESP) ? (winner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_reg_file_arb.sv
// Testbench for reg_file_arb: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_reg_file_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_wr, m_gnt, m_ack;
  logic [63:0] m_addr, m_wr_data;
  logic [31:0] m_rd_data, rf_addr, rf_wr_data, rf_rd_data;
  logic [7:0]  m_err, rf_err;
  logic        rf_req, rf_wr, rf_ack, busy;

  int   errors = 0;
  int   checks = 0;
  logic rr = 1'b0;

  always #5 clk = ~clk;

  reg_file_arb #(.ADDR_W(32), .DATA_W(32), .ERR_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_gnt(m_gnt), .m_ack(m_ack), .m_rd_data(m_rd_data),
    .m_err(m_err), .rf_req(rf_req), .rf_wr(rf_wr), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_ack(rf_ack),
    .rf_err(rf_err), .busy(busy)
  );

  // One full transaction with the requester vectors already driven by the caller.
  task automatic run_txn(input string tag, input int k, input logic [31:0] rd,
                         input logic [7:0] err, input bit stray, input bit keep);
    logic w, ewr;
    logic [1:0] oh;
    logic [31:0] ea, ed, erd;
    w   = (m_req == 2'b11) ? rr : m_req[1];
    oh  = w ? 2'b10 : 2'b01;
    ewr = m_wr[w];
    ea  = w ? m_addr[63:32] : m_addr[31:0];
    ed  = w ? m_wr_data[63:32] : m_wr_data[31:0];
    erd = ewr ? 32'h0 : rd;
    @(negedge clk);
    checks++; if (m_gnt !== oh) begin errors++; $display("FAIL %s gnt: got %b want %b", tag, m_gnt, oh); end
    checks++; if (rf_req !== 1'b1) begin errors++; $display("FAIL %s rf_req: got %b want 1", tag, rf_req); end
    checks++; if (rf_wr !== ewr) begin errors++; $display("FAIL %s rf_wr: got %b want %b", tag, rf_wr, ewr); end
    checks++; if (rf_addr !== ea) begin errors++; $display("FAIL %s rf_addr: got %h want %h", tag, rf_addr, ea); end
    checks++; if (rf_wr_data !== ed) begin errors++; $display("FAIL %s rf_wr_data: got %h want %h", tag, rf_wr_data, ed); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", tag, busy); end
    if (!keep) m_req[w] = 1'b0;
    if (stray) begin rf_ack = 1'b1; rf_rd_data = $urandom; rf_err = 8'($urandom); end
    @(negedge clk);
    rf_ack = 1'b0;
    checks++; if (m_gnt !== 2'b00 || rf_req !== 1'b0) begin errors++; $display("FAIL %s issue_end: got gnt=%b req=%b want 00/0", tag, m_gnt, rf_req); end
    for (int i = 0; i < k; i++) begin
      checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL %s early_ack: got %b want 00", tag, m_ack); end
      @(negedge clk);
    end
    rf_ack = 1'b1; rf_rd_data = rd; rf_err = err;
    @(negedge clk);
    rf_ack = 1'b0; rf_rd_data = $urandom; rf_err = 8'($urandom);
    checks++; if (m_ack !== oh) begin errors++; $display("FAIL %s ack: got %b want %b", tag, m_ack, oh); end
    checks++; if (m_rd_data !== erd) begin errors++; $display("FAIL %s rd_data: got %h want %h", tag, m_rd_data, erd); end
    checks++; if (m_err !== err) begin errors++; $display("FAIL %s err: got %h want %h", tag, m_err, err); end
    rr = ~w;
    @(negedge clk);
    checks++; if (m_ack !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL %s idle: got ack=%b busy=%b want 00/0", tag, m_ack, busy); end
    checks++; if (m_rd_data !== erd || m_err !== err) begin errors++; $display("FAIL %s hold: got %h/%h want %h/%h", tag, m_rd_data, m_err, erd, err); end
    checks++; if (rf_addr !== ea || rf_wr !== ewr) begin errors++; $display("FAIL %s rf_hold: got %h/%b want %h/%b", tag, rf_addr, rf_wr, ea, ewr); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 2'b11; m_wr = 2'b11; m_addr = '1; m_wr_data = '1;
    rf_ack = 1'b1; rf_rd_data = 32'hFFFF_FFFF; rf_err = 8'hAA;
    @(negedge clk); @(negedge clk);
    checks++; if (m_gnt !== 2'b00 || m_ack !== 2'b00) begin errors++; $display("FAIL reset_hs: got gnt=%b ack=%b want 00/00", m_gnt, m_ack); end
    checks++; if (rf_req !== 1'b0 || rf_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctl: got req=%b wr=%b busy=%b want 0", rf_req, rf_wr, busy); end
    checks++; if (m_rd_data !== 32'h0 || m_err !== 8'h0) begin errors++; $display("FAIL reset_resp: got %h/%h want 0/0", m_rd_data, m_err); end
    checks++; if (rf_addr !== 32'h0 || rf_wr_data !== 32'h0) begin errors++; $display("FAIL reset_rf: got %h/%h want 0/0", rf_addr, rf_wr_data); end
    m_req = 2'b00; m_wr = 2'b00; m_addr = '0; m_wr_data = '0;
    rst = 1'b0; rr = 1'b0;
    @(negedge clk);
    rf_ack = 1'b0;
    checks++; if (busy !== 1'b0 || m_ack !== 2'b00) begin errors++; $display("FAIL reset_stray_ack: got busy=%b ack=%b want 0/00", busy, m_ack); end
  endtask

  task automatic test_single_read();
    m_req = 2'b01; m_wr = 2'b00; m_addr = {32'h0000_0100, 32'h0000_0004};
    m_wr_data = {32'h1111_1111, 32'h2222_2222};
    run_txn("single_read", 0, 32'hDEAD_BEEF, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_contention();
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    do_reset();
    m_req = 2'b11; m_wr = 2'b00; m_addr = {32'h0000_0020, 32'h0000_0010};
    m_wr_data = {32'hB0B0_B0B0, 32'hA0A0_A0A0};
    for (int i = 0; i < 4; i++) begin
      checks++; if ((rr ? 2'b10 : 2'b01) !== order[i]) begin errors++; $display("FAIL contention_model %0d: got %b want %b", i, rr ? 2'b10 : 2'b01, order[i]); end
      run_txn("contention", i, 32'hC000_0000 + i, 8'(i), 1'b0, 1'b1);
    end
    m_req = 2'b00;
  endtask

  task automatic test_write_resp();
    m_req = 2'b10; m_wr = 2'b10; m_addr = {32'h0000_0008, 32'h0000_0000};
    m_wr_data = {32'h1234_5678, 32'h0};
    run_txn("write_resp", 2, 32'h5A5A_5A5A, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_req[i] && ($urandom_range(0, 2) != 0)) begin
          m_req[i] = 1'b1;
          m_wr[i]  = 1'($urandom);
          if (i == 0) begin m_addr[31:0] = $urandom; m_wr_data[31:0] = $urandom; end
          else        begin m_addr[63:32] = $urandom; m_wr_data[63:32] = $urandom; end
        end
      end
      if (m_req == 2'b00) begin m_req[0] = 1'b1; m_wr[0] = 1'($urandom); m_addr[31:0] = $urandom; end
      run_txn("random", int'($urandom_range(0, 4)), $urandom, 8'($urandom),
              1'($urandom), 1'b0);
    end
    m_req = 2'b00;
  endtask

  task automatic test_timeout();
    m_req = 2'b01; m_wr = 2'b00; m_addr[31:0] = 32'h40;
    @(negedge clk);
    checks++; if (m_gnt !== 2'b01) begin errors++; $display("FAIL timeout_gnt: got %b want 01", m_gnt); end
    m_req = 2'b00;
    @(negedge clk);
`ifdef REG_FILE_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL timeout_early: cycle %0d got %b want 00", i, m_ack); end
      @(negedge clk);
    end
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL timeout_ack: got %b want 01", m_ack); end
    checks++; if (m_rd_data !== 32'h0 || m_err !== 8'hFF) begin errors++; $display("FAIL timeout_resp: got %h/%h want 0/ff", m_rd_data, m_err); end
    rr = 1'b1;
    @(negedge clk);
    rf_ack = 1'b1; rf_rd_data = 32'h7777_7777; rf_err = 8'h05;
    @(negedge clk);
    rf_ack = 1'b0;
    checks++; if (m_ack !== 2'b00 || busy !== 1'b0 || m_err !== 8'hFF || m_rd_data !== 32'h0) begin errors++; $display("FAIL timeout_late_ack: got ack=%b busy=%b %h/%h", m_ack, busy, m_rd_data, m_err); end
`else
    for (int i = 0; i < 40; i++) begin
      checks++; if (m_ack !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL no_timeout: cycle %0d got ack=%b busy=%b want 00/1", i, m_ack, busy); end
      @(negedge clk);
    end
    rf_ack = 1'b1; rf_rd_data = 32'h0000_A5A5; rf_err = 8'h03;
    @(negedge clk);
    rf_ack = 1'b0;
    checks++; if (m_ack !== 2'b01 || m_rd_data !== 32'h0000_A5A5 || m_err !== 8'h03) begin errors++; $display("FAIL no_timeout_ack: got %b %h/%h want 01 0000a5a5/03", m_ack, m_rd_data, m_err); end
    rr = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_in_wait();
    m_req = 2'b01; m_wr = 2'b00; m_addr = {32'h0000_0200, 32'h0000_0100};
    run_txn("riw_pre", 0, 32'h0BAD_F00D, 8'h02, 1'b0, 1'b0);
    m_req = 2'b11;
    @(negedge clk);
    checks++; if (m_gnt !== 2'b10) begin errors++; $display("FAIL riw_gnt: got %b want 10", m_gnt); end
    m_req = 2'b00;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rr = 1'b0;
    checks++; if (busy !== 1'b0 || m_ack !== 2'b00 || m_gnt !== 2'b00) begin errors++; $display("FAIL riw_reset: got busy=%b ack=%b gnt=%b want 0/00/00", busy, m_ack, m_gnt); end
    checks++; if (m_rd_data !== 32'h0 || m_err !== 8'h0) begin errors++; $display("FAIL riw_resp_clr: got %h/%h want 0/0", m_rd_data, m_err); end
    rf_ack = 1'b1; rf_rd_data = 32'h9999_9999; rf_err = 8'h09;
    @(negedge clk);
    rf_ack = 1'b0;
    checks++; if (m_ack !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL riw_late_ack: got ack=%b busy=%b want 00/0", m_ack, busy); end
    @(negedge clk);
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL riw_late_ack2: got %b want 00", m_ack); end
    m_req = 2'b11; m_wr = 2'b01; m_wr_data = {32'h0, 32'hFEED_FACE};
    run_txn("riw_post", 1, 32'h0, 8'h00, 1'b0, 1'b0);
    m_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_resp();
    test_random();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
